// File: rtl/smc_rd_xbar_pkg.sv
// Shared types and width helpers for the SMC read crossbar.
// Arbitration mode encoding plus id and counter width derivation.
package smc_rd_xbar_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    ARB_RR = 1'b0,
    ARB_FP = 1'b1
  } arb_mode_e;

  // A single master still needs a 1-bit id so out-of-range ids remain expressible.
  function automatic int id_w(int n);
    int nn;
    nn = (n > MAX_N) ? MAX_N : n;
    return (nn <= 1) ? 1 : $clog2(nn);
  endfunction

  function automatic int cnt_w(int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/smc_rr_arb.sv
// N-way arbiter with round-robin or fixed-priority selection.
// The rotation pointer moves past the winner only when a grant is taken.
module smc_rr_arb import smc_rd_xbar_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  arb_mode_e     mode,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (mode == ARB_RR) ? ((int'(ptr) + i) % N) : i;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (|req) && (mode == ARB_RR)) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/smc_rd_xbar.sv
// Read-path crossbar: N masters share one SMC read port through a registered
// address stage; read data is steered back by the returned id.
module smc_rd_xbar import smc_rd_xbar_pkg::*; #(
  parameter int N        = 4,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int LW       = 8,
  parameter int ID_W     = id_w(N),
  parameter int MAX_OUT  = 4,
  parameter int ARB_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*LW-1:0] m_len,
  input  logic [N-1:0]    m_avalid,
  output logic [N-1:0]    m_aready,
  output logic [N*DW-1:0] m_data,
  output logic [N-1:0]    m_last,
  output logic [N-1:0]    m_valid,
  input  logic [N-1:0]    m_ready,
  output logic [AW-1:0]   s_addr,
  output logic [LW-1:0]   s_len,
  output logic [ID_W-1:0] s_aid,
  output logic            s_avalid,
  input  logic            s_aready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  input  logic [ID_W-1:0] s_id,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            err_id
);

  localparam int CW = cnt_w(MAX_OUT);

  logic            load;
  logic            id_ok;
  logic [N-1:0]    elig;
  logic [N-1:0]    gnt;
  logic [N-1:0]    dec;
  logic [ID_W-1:0] win_idx;
  logic [CW-1:0]   cnt [N];
  arb_mode_e       mode;

  assign mode     = (ARB_MODE == 1) ? ARB_FP : ARB_RR;
  assign load     = ~s_avalid | s_aready;
  assign m_aready = load ? gnt : '0;
  assign id_ok    = (int'(s_id) < N);

  always_comb begin
    elig = '0;
    dec  = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = m_avalid[i] && (cnt[i] < CW'(MAX_OUT));
      dec[i]  = s_valid && s_ready && s_last && (s_id == ID_W'(i)) && (cnt[i] != '0);
    end
  end

  smc_rr_arb #(.N(N), .IW(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .mode    (mode),
    .advance (load),
    .gnt     (gnt),
    .idx     (win_idx)
  );

  // Payload is only reloaded when a winner exists; s_avalid alone marks it stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_avalid <= 1'b0;
      s_addr   <= '0;
      s_len    <= '0;
      s_aid    <= '0;
    end else if (load) begin
      s_avalid <= |gnt;
      if (|gnt) begin
        s_addr <= m_addr[int'(win_idx)*AW +: AW];
        s_len  <= m_len[int'(win_idx)*LW +: LW];
        s_aid  <= win_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({m_aready[i], dec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Unmatched ids fall through with s_ready=1 so stray beats are drained.
  always_comb begin
    m_valid = '0;
    s_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (s_id == ID_W'(i)) begin
        m_valid[i] = s_valid;
        s_ready    = m_ready[i];
      end
    end
  end

  assign m_data = {N{s_data}};
  assign m_last = {N{s_last}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_id <= 1'b0;
    else if (s_valid && !id_ok) err_id <= 1'b1;
  end

endmodule
